// File: rtl/div_unit_pkg.sv
// Shared definitions for the integer divider and the decode logic that drives it.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    DIV_NONE = 3'b000,
    DIV      = 3'b001,
    DIVU     = 3'b010,
    REM      = 3'b011,
    REMU     = 3'b100
  } div_op_e;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic logic op_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem,quo} left, trial-subtract, keep or restore.
module div_step
  import div_unit_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] rem_sh;
  logic [W:0] trial;

  // Trial subtraction uses one extra bit so the borrow shows up as the sign.
  always_comb begin
    rem_sh = {rem_in, quo_in[W-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[W]) begin
      rem_out = trial[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b1};
    end else begin
      rem_out = rem_sh[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//
// state  | meaning
// S_IDLE | waiting for an accepted start; special cases resolve here
// S_CALC | one quotient bit per clock, XLEN iterations
// S_DONE | result valid for one cycle, done pulses unless killed
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  div_op_e         op_q;
  logic            q_neg_q, r_neg_q;
  logic [XLEN-1:0] dvsr_q, rem_q, quo_q, result_q;

  div_op_e         op_in;
  logic            accept, is_special, last_iter;
  logic            a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic [XLEN-1:0] step_rem, step_quo, fin_quo, fin_rem, fin_res;

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Operand conditioning, special-case detection and final sign fix-up.
  always_comb begin
    op_in    = div_op_e'(divsel);
    a_neg    = op_signed(op_in) & dividend[XLEN-1];
    b_neg    = op_signed(op_in) & divisor[XLEN-1];
    a_abs    = a_neg ? -dividend : dividend;
    b_abs    = b_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    ovf      = op_signed(op_in) && (dividend == INT_MIN) && (divisor == '1);
    is_special = div_zero | ovf;
    if (div_zero)
      special_res = ((op_in == DIV) || (op_in == DIVU)) ? DIV_ZERO_Q : dividend;
    else
      special_res = (op_in == DIV) ? INT_MIN : '0;
    fin_quo   = q_neg_q ? -step_quo : step_quo;
    fin_rem   = r_neg_q ? -step_rem : step_rem;
    fin_res   = ((op_q == DIV) || (op_q == DIVU)) ? fin_quo : fin_rem;
    last_iter = (cnt_q == CNT_W'(XLEN - 1));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept = start & ~kill & op_valid(divsel);
        busy   = accept;
        if (accept) state_d = is_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (kill)           state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        done    = ~kill;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch operands on accept, iterate in CALC, load result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= DIV_NONE;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      op_q    <= op_in;
      q_neg_q <= (op_in == DIV) & (a_neg ^ b_neg);
      r_neg_q <= (op_in == REM) & a_neg;
      dvsr_q  <= b_abs;
      rem_q   <= '0;
      quo_q   <= a_abs;
      if (is_special) result_q <= special_res;
    end else if (state_q == S_CALC && !kill) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= step_rem;
      quo_q <= step_quo;
      if (last_iter) result_q <= fin_res;
    end
  end

  assign result = result_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage, directly downstream of the decode control logic.
- Consumes that logic's div_inst/divsel outputs plus the forwarded rs1/rs2 operands.
- Drives a stall request into the hazard path and delivers one registered 32-bit result per operation.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  div_inst from decode; request a new operation.
- divsel  in  3  001 DIV, 010 DIVU, 011 REM, 100 REMU; all other codes are invalid.
- dividend  in  XLEN  rs1 value.
- divisor  in  XLEN  rs2 value.
- kill  in  1  pipeline flush; abandons any operation.
- busy  out  1  stall request to the hazard path.
- done  out  1  one-cycle result-valid pulse.
- result  out  XLEN  quotient or remainder.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; counter, operand, quotient, remainder and result registers = 0.
  - busy=0, done=0.
  - Reset takes effect immediately, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - A start is accepted when start=1, kill=0 and divsel is valid. Otherwise stay in IDLE and ignore start.
  - On acceptance, latch divsel, the operand signs and the absolute values (signed ops only; unsigned ops take operands raw).
  - Special cases go IDLE->DONE with the result computed directly:
    - Divisor==0: quotient=all ones; remainder=dividend (unmodified).
    - Signed overflow (DIV/REM with dividend=0x80000000, divisor=0xFFFFFFFF): quotient=0x80000000; remainder=0.
  - All other accepted starts: IDLE->CALC with counter=0, partial remainder=0, quotient register=|dividend|.
- CALC (one iteration per edge):
  - Shift {rem,quo} left by 1.
  - Trial-subtract |divisor| from rem using XLEN+1 bits.
  - If the trial result is non-negative, keep it and set quo[0]=1; otherwise restore rem and set quo[0]=0.
  - Increment counter; after the XLEN-th iteration go to DONE.
  - On that transition load result: quotient negated when DIV and signs differ; remainder negated when REM and the dividend was negative.
  - Select quotient for DIV/DIVU, remainder for REM/REMU.
- DONE:
  - done = (state==DONE) & !kill.
  - Always return to IDLE next edge. start is not accepted while in DONE.
- Latency (start sampled at edge 0):
  - Normal ops: done is visible in the cycle after edge XLEN (33 cycles for XLEN=32).
  - Special cases: done is visible in the cycle after edge 0.
- busy = (state==IDLE & start & !kill & divsel valid) | (state==CALC).
  - busy is low in DONE, so the stalled instruction advances while result is valid.
- result holds its value after DONE until the next accepted start loads new contents; it is never cleared by kill.
- kill in CALC or DONE: next state IDLE, done suppressed, no result update.
- Counter width is $clog2(XLEN)+1; counter wrap cannot occur because CALC exits at XLEN.
- No back-to-back acceptance: a second start issued during the DONE cycle is ignored. Decode re-presents it in IDLE.

Decomposition:
- Shared core package:
  - div_op_e enum (DIV_NONE=000, DIV=001, DIVU=010, REM=011, REMU=100). The decode logic adopts the same enum for divsel.
  - XLEN constant.
  - DIV_ZERO_Q constant (all ones).
- One sub-module, div_step: combinational single restoring iteration (rem, quo, divisor in -> rem, quo out).

Test Plan:
1. DIV 7 / -2 -> result 0xFFFFFFFD; REM 7 % -2 -> 1; REM -7 % 2 -> 0xFFFFFFFF. Each has done one cycle, 33 cycles after start; busy high for 33 cycles.
2. DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU same operands -> 1; DIVU 3 / 5 -> 0.
3. DIV 5 / 0 -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 % 0 -> 5. Each has done on the cycle after start.
4. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; done after 1 cycle.
5. kill at CALC iteration 10 -> done never pulses, result unchanged, busy low next cycle. A new DIVU 100 / 7 -> 14 completes normally afterwards.
6. rst_n low mid-CALC -> state IDLE, busy/done/result 0 without a clock edge. Start with divsel=101 -> ignored, busy stays 0.
